// File: rtl/ipv4_checksum_arbiter_if.sv
// rtl/ipv4_checksum_arbiter_if.sv - header request, verifier and result stream bundle
interface ipv4_checksum_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int TID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_tvalid;
    logic [NUM_REQ-1:0]        req_tready;
    logic [NUM_REQ-1:0][159:0] req_tdata;
    logic                      chk_hdr_tvalid;
    logic [159:0]              chk_hdr_tdata;
    logic                      chk_res_tvalid;
    logic                      chk_res_tdata;
    logic                      res_tvalid;
    logic                      res_tdata;
    logic [TID_W-1:0]          res_tid;

    modport slave (
        input  req_tvalid, req_tdata, chk_res_tvalid, chk_res_tdata,
        output req_tready, chk_hdr_tvalid, chk_hdr_tdata, res_tvalid, res_tdata, res_tid
    );

    modport master (
        output req_tvalid, req_tdata, chk_res_tvalid, chk_res_tdata,
        input  req_tready, chk_hdr_tvalid, chk_hdr_tdata, res_tvalid, res_tdata, res_tid
    );
endinterface

// File: rtl/ipv4_checksum_arbiter.sv
// rtl/ipv4_checksum_arbiter.sv - round-robin IPv4 header arbiter for a shared checksum verifier
module ipv4_checksum_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         aresetn,
    ipv4_checksum_arbiter_if.slave       bus,
    input  logic                         counters_clear,
    output logic [15:0]                  pass_count,
    output logic [15:0]                  fail_count,
    output logic                         err_unexpected
);
    localparam int TID_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    logic [TID_W-1:0] rr_ptr;
    logic [TID_W-1:0] grant_idx;
    logic [TID_W-1:0] cand;
    logic             grant_ok;
    int               idx;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [TID_W-1:0] tag_mem [MAX_OUTSTANDING];
    logic             room;
    logic             accept;
    logic             pop;

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        grant_ok  = 1'b0;
        grant_idx = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = TID_W'(idx);
            if (!grant_ok && bus.req_tvalid[cand]) begin
                grant_ok  = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Room comes from the registered count, so a slot freed by a pop is only usable next cycle.
    assign room   = (count < CNT_W'(MAX_OUTSTANDING));
    assign accept = aresetn && room && grant_ok;
    assign pop    = bus.chk_res_tvalid && (count != '0);

    always_comb begin
        bus.req_tready = '0;
        if (accept) bus.req_tready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept) tag_mem[wr_ptr] <= grant_idx;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr             <= TID_W'(NUM_REQ - 1);
            count              <= '0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            bus.chk_hdr_tvalid <= 1'b0;
            bus.chk_hdr_tdata  <= '0;
            bus.res_tvalid     <= 1'b0;
            bus.res_tdata      <= 1'b0;
            bus.res_tid        <= '0;
            pass_count         <= '0;
            fail_count         <= '0;
            err_unexpected     <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr            <= grant_idx;
                wr_ptr            <= wr_ptr + PTR_W'(1);
                bus.chk_hdr_tdata <= bus.req_tdata[grant_idx];
            end
            bus.chk_hdr_tvalid <= accept;

            if (pop) begin
                rd_ptr        <= rd_ptr + PTR_W'(1);
                bus.res_tid   <= tag_mem[rd_ptr];
                bus.res_tdata <= bus.chk_res_tdata;
            end
            bus.res_tvalid <= pop;

            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (counters_clear) begin
                pass_count     <= '0;
                fail_count     <= '0;
                err_unexpected <= 1'b0;
            end else begin
                if (bus.res_tvalid && bus.res_tdata && (pass_count != 16'hFFFF))
                    pass_count <= pass_count + 16'd1;
                if (bus.res_tvalid && !bus.res_tdata && (fail_count != 16'hFFFF))
                    fail_count <= fail_count + 16'd1;
                if (bus.chk_res_tvalid && (count == '0))
                    err_unexpected <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ipv4_checksum_arbiter.sv
// tb/tb_ipv4_checksum_arbiter.sv - self-checking bench for ipv4_checksum_arbiter
module tb_ipv4_checksum_arbiter;
    localparam int N = 4;
    localparam int M = 4;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        counters_clear;
    logic [15:0] pass_count;
    logic [15:0] fail_count;
    logic        err_unexpected;

    always #5 clk = ~clk;

    ipv4_checksum_arbiter_if #(.NUM_REQ(N)) bus();

    ipv4_checksum_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(M)) dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .bus            (bus),
        .counters_clear (counters_clear),
        .pass_count     (pass_count),
        .fail_count     (fail_count),
        .err_unexpected (err_unexpected)
    );

    int total = 0;
    int bad   = 0;

    int           m_rr;
    int           m_q[$];
    int           m_pass, m_fail;
    bit           m_err;
    bit           m_hdr_v;
    logic [159:0] m_hdr_d;
    bit           m_res_v, m_res_d;
    int           m_tid;
    logic [3:0]   last_ready;
    int           dut_acc;

    typedef struct {
        bit         rst;
        logic [3:0] valid;
        bit         rv, rd, clr;
        logic [3:0] e_ready;
        bit         e_hdr, e_res;
        int         e_tid;
        int         e_pass;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = N - 1;
        m_q.delete();
        m_pass = 0; m_fail = 0; m_err = 0;
        m_hdr_v = 0; m_hdr_d = '0;
        m_res_v = 0; m_res_d = 0; m_tid = 0;
    endtask

    task automatic rand_data();
        for (int r = 0; r < N; r++)
            for (int w = 0; w < 5; w++)
                bus.req_tdata[r][w*32 +: 32] = $urandom;
    endtask

    // Entered at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        int         g;
        int         j;
        bit         empty;
        logic [1:0] jj;
        logic [3:0] exp_ready;
        g = -1;
        #1;
        if (m_q.size() < M)
            for (int k = 1; k <= N; k++) begin
                j  = (m_rr + k) % N;
                jj = 2'(j);
                if (g < 0 && bus.req_tvalid[jj]) g = j;
            end
        exp_ready  = (g >= 0) ? 4'(1 << g) : 4'd0;
        last_ready = bus.req_tready;
        chk("req_tready", bus.req_tready, exp_ready);
        if ((bus.req_tready & bus.req_tvalid) != 0) dut_acc++;

        empty = (m_q.size() == 0);
        if (counters_clear) begin
            m_pass = 0; m_fail = 0; m_err = 0;
        end else begin
            if (m_res_v && m_res_d && m_pass < 65535) m_pass++;
            if (m_res_v && !m_res_d && m_fail < 65535) m_fail++;
            if (bus.chk_res_tvalid && empty) m_err = 1;
        end
        m_res_v = bus.chk_res_tvalid && !empty;
        if (m_res_v) begin
            m_tid   = m_q.pop_front();
            m_res_d = bus.chk_res_tdata;
        end
        m_hdr_v = (g >= 0);
        if (g >= 0) begin
            jj      = 2'(g);
            m_hdr_d = bus.req_tdata[jj];
            m_q.push_back(g);
            m_rr = g;
        end

        @(posedge clk);
        #1;
        chk("chk_hdr_tvalid", bus.chk_hdr_tvalid, m_hdr_v);
        if (m_hdr_v) chk("chk_hdr_tdata", bus.chk_hdr_tdata, m_hdr_d);
        chk("res_tvalid", bus.res_tvalid, m_res_v);
        if (m_res_v) begin
            chk("res_tid", bus.res_tid, m_tid);
            chk("res_tdata", bus.res_tdata, m_res_d);
        end
        chk("pass_count", pass_count, m_pass);
        chk("fail_count", fail_count, m_fail);
        chk("err_unexpected", err_unexpected, m_err);
        @(negedge clk);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        #1;
        chk("rst req_tready", bus.req_tready, 0);
        chk("rst chk_hdr_tvalid", bus.chk_hdr_tvalid, 0);
        chk("rst chk_hdr_tdata", bus.chk_hdr_tdata, 0);
        chk("rst res_tvalid", bus.res_tvalid, 0);
        chk("rst res_tdata", bus.res_tdata, 0);
        chk("rst res_tid", bus.res_tid, 0);
        chk("rst pass_count", pass_count, 0);
        chk("rst fail_count", fail_count, 0);
        chk("rst err_unexpected", err_unexpected, 0);
        @(negedge clk);
        aresetn = 1'b1;
        model_reset();
    endtask

    task automatic set_in(input logic [3:0] v, input bit rv, input bit rd, input bit clr);
        bus.req_tvalid     = v;
        bus.chk_res_tvalid = rv;
        bus.chk_res_tdata  = rd;
        counters_clear     = clr;
    endtask

    initial begin
        //          rst valid    rv rd clr e_ready  hdr res tid pass
        tbl[0] = '{0, 4'b0100, 0, 0, 0, 4'b0100, 1, 0, 0, 0};
        tbl[1] = '{0, 4'b0000, 1, 1, 0, 4'b0000, 0, 1, 2, 0};
        tbl[2] = '{0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0, 1};
        tbl[3] = '{1, 4'b1111, 0, 0, 0, 4'b0001, 1, 0, 0, 0};
        tbl[4] = '{0, 4'b1111, 1, 1, 0, 4'b0010, 1, 1, 0, 0};
        tbl[5] = '{0, 4'b1111, 1, 1, 0, 4'b0100, 1, 1, 1, 1};
        tbl[6] = '{0, 4'b1111, 1, 0, 0, 4'b1000, 1, 1, 2, 2};
        tbl[7] = '{0, 4'b1111, 1, 1, 0, 4'b0001, 1, 1, 3, 2};
        tbl[8] = '{0, 4'b0000, 1, 1, 1, 4'b0000, 0, 1, 0, 0};
        tbl[9] = '{0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0, 1};

        aresetn = 1'b0;
        set_in(4'b0000, 0, 0, 0);
        bus.req_tdata = '0;
        dut_acc = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rst) do_reset();
            set_in(tbl[i].valid, tbl[i].rv, tbl[i].rd, tbl[i].clr);
            rand_data();
            cycle();
            chk($sformatf("vec%0d ready", i), last_ready, tbl[i].e_ready);
            chk($sformatf("vec%0d hdr_v", i), bus.chk_hdr_tvalid, tbl[i].e_hdr);
            chk($sformatf("vec%0d res_v", i), bus.res_tvalid, tbl[i].e_res);
            if (tbl[i].e_res) chk($sformatf("vec%0d tid", i), bus.res_tid, tbl[i].e_tid);
            chk($sformatf("vec%0d pass", i), pass_count, tbl[i].e_pass);
        end

        // Slow verifier: four accepts fill the tag FIFO, then grants stop.
        do_reset();
        dut_acc = 0;
        set_in(4'b1111, 0, 0, 0);
        for (int c = 0; c < 20; c++) begin
            rand_data();
            cycle();
            if (c >= 4) chk("full ready", last_ready, 0);
        end
        chk("full accepts", dut_acc, 4);
        set_in(4'b1111, 1, 1, 0);
        cycle();
        chk("full first tid", bus.res_tid, 0);
        chk("full no grant on pop", last_ready, 0);
        for (int c = 0; c < 10; c++) begin
            rand_data();
            cycle();
        end

        // Spurious result, then clear.
        do_reset();
        set_in(4'b0000, 1, 1, 0);
        cycle();
        chk("spur err", err_unexpected, 1);
        chk("spur res_v", bus.res_tvalid, 0);
        chk("spur pass", pass_count, 0);
        set_in(4'b0000, 0, 0, 1);
        cycle();
        chk("clear err", err_unexpected, 0);

        // Reset with three headers in flight.
        do_reset();
        set_in(4'b1111, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            rand_data();
            cycle();
        end
        do_reset();
        set_in(4'b0000, 1, 1, 0);
        cycle();
        chk("post-rst err", err_unexpected, 1);
        chk("post-rst res_v", bus.res_tvalid, 0);

        // Random traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rand_data();
            set_in(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 4), 1'($urandom),
                   ($urandom_range(0, 49) == 0));
            cycle();
        end

        // Pass counter saturation.
        do_reset();
        set_in(4'b0001, 1, 1, 0);
        for (int c = 0; c < 70010; c++) cycle();
        chk("sat pass", pass_count, 16'hFFFF);
        for (int c = 0; c < 5; c++) cycle();
        chk("sat hold", pass_count, 16'hFFFF);
        chk("sat fail", fail_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ipv4_checksum_arbiter.md
IPV4_CHECKSUM_ARBITER -- requirements
Module: ipv4_checksum_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of header requesters (2..8).
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 4, giving the number of headers in flight in the shared verifier (power of 2, 2..16).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1: the single clock.
REQ-005 Port aresetn, input, 1: asynchronous active-low reset.
REQ-006 Port req_tvalid, input, NUM_REQ: per-requester header valid.
REQ-007 Port req_tready, output, NUM_REQ: per-requester accept, combinational grant.
REQ-008 Port req_tdata, input, NUM_REQ x 160: per-requester 20-byte IPv4 header, network bit order.
REQ-009 Port chk_hdr_tvalid, output, 1: header issue to the shared checksum verifier; no backpressure.
REQ-010 Port chk_hdr_tdata, output, 160: header to the verifier.
REQ-011 Port chk_res_tvalid, input, 1: verifier result strobe.
REQ-012 Port chk_res_tdata, input, 1: verifier result; 1 = checksum good.
REQ-013 Port res_tvalid, output, 1: routed result strobe; no backpressure.
REQ-014 Port res_tdata, output, 1: pass bit, copied from chk_res_tdata.
REQ-015 Port res_tid, output, clog2(NUM_REQ): index of the requester owning the result.
REQ-016 Port pass_count, output, 16: number of good results.
REQ-017 Port fail_count, output, 16: number of bad results.
REQ-018 Port err_unexpected, output, 1: sticky flag; a result arrived with nothing outstanding.
REQ-019 Port counters_clear, input, 1: synchronous clear of the counters and of err_unexpected.

Function
REQ-020 The grant SHALL be round-robin. The search SHALL start at index rr_ptr+1 modulo NUM_REQ and take the first asserted req_tvalid.
REQ-021 A grant SHALL be issued only when the outstanding count, taken from a register, is below MAX_OUTSTANDING. At most one req_tready SHALL be high per cycle.
REQ-022 On accept (req_tvalid & req_tready), rr_ptr SHALL update to the granted index. rr_ptr SHALL hold when nothing is accepted.
REQ-023 Issue SHALL be registered. chk_hdr_tvalid SHALL be high for exactly 1 cycle, the cycle after accept, with chk_hdr_tdata equal to the accepted header.
REQ-024 On accept, the requester index SHALL be pushed into an in-order tag FIFO of depth MAX_OUTSTANDING.
REQ-025 On chk_res_tvalid with the FIFO non-empty, the head tag SHALL be popped.
REQ-026 One cycle after a pop, res_tvalid SHALL be 1 for 1 cycle, with res_tid equal to the popped tag and res_tdata equal to the sampled chk_res_tdata.
REQ-027 A push and a pop in the same cycle SHALL leave the count unchanged, including at count = MAX_OUTSTANDING - 1.
REQ-028 A full FIFO SHALL block grants.
REQ-029 A pop that frees a slot SHALL allow a grant no earlier than the following cycle.
REQ-030 chk_res_tvalid with the FIFO empty SHALL set err_unexpected. It SHALL produce no res_tvalid and leave the counters unchanged.
REQ-031 For each res_tvalid, pass_count SHALL increment when res_tdata = 1 and fail_count SHALL increment when res_tdata = 0.
REQ-032 Each counter SHALL saturate at 0xFFFF.
REQ-033 counters_clear SHALL zero both counters and err_unexpected in the next cycle. It SHALL take priority over an increment in the same cycle.
REQ-034 The read and write pointers of the tag FIFO SHALL wrap modulo MAX_OUTSTANDING.

Reset
REQ-035 While aresetn = 0, the following outputs SHALL be 0: req_tready, chk_hdr_tvalid, res_tvalid, res_tdata, res_tid, pass_count, fail_count, err_unexpected.
REQ-036 While aresetn = 0, chk_hdr_tdata SHALL be 0, rr_ptr SHALL be NUM_REQ-1 (so that index 0 wins first), and the FIFO SHALL be empty.
REQ-037 Reset asserted mid-operation SHALL discard all outstanding tags.
REQ-038 A verifier result arriving after reset SHALL be treated per REQ-030.

Verification
REQ-039 Single requester 2 sends one valid header; verifier answers good 1 cycle after issue -> chk_hdr_tvalid 1 cycle after accept; res_tid = 2, res_tdata = 1; pass_count = 1.
REQ-040 All 4 requesters hold tvalid continuously from reset -> accept order 0,1,2,3,0,...; each result tagged in the same order.
REQ-041 Verifier result delayed 20 cycles, all requesters active -> exactly 4 accepts, then req_tready = 0 until the first result; no tag lost or reordered.
REQ-042 Spurious chk_res_tvalid with nothing outstanding -> err_unexpected = 1, no res_tvalid; counters_clear -> err_unexpected = 0 next cycle.
REQ-043 70000 good results with counters_clear never asserted -> pass_count = 0xFFFF and holds there.
REQ-044 aresetn pulsed with 3 headers in flight -> all outputs at reset values; a later verifier result sets err_unexpected.
